// File: rtl/fifo_2c_pop_reader.sv
// fifo_2c_pop_reader
// Destination-domain reader for the pop side of a dual-clock FIFO. It issues
// pops and absorbs the FIFO's registered read latency (RD_LAT, legal 0..2)
// through a small skid buffer of RD_LAT+1 words. Output is a valid/ready
// stream that sustains one word per cycle under backpressure. It also
// sequences a FIFO clear on request: drain, discard, pulse clr, then wait.
module fifo_2c_pop_reader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_d,
    input  logic             rst_d,
    input  logic             fifo_empty_d,
    input  logic [WIDTH-1:0] fifo_data_d,
    output logic             fifo_pop_d_n,
    output logic             fifo_clr_d,
    input  logic             fifo_clr_cmplt_d,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic [CNT_W-1:0] word_cnt
);

    // Buffer depth covers every word that can be in flight plus the head.
    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BC_W  = $clog2(DEPTH + 1);
    localparam int unsigned SR_W  = (RD_LAT > 0) ? RD_LAT : 1;
    localparam int unsigned SUM_W = BC_W + 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_nxt;

    logic [WIDTH-1:0]   buf_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [BC_W-1:0]    buf_cnt_q;
    logic [SR_W-1:0]    sr_q;
    logic [CNT_W-1:0]   word_cnt_q;

    logic               xfer_c;
    logic               pop_c;
    logic               capture_c;
    logic               wr_en_c;
    logic               buf_clr_c;
    logic [SUM_W-1:0]   inflight_c;
    logic [SUM_W-1:0]   occ_c;

    // Wrapping pointer increment for a depth that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Stream side: valid whenever the buffer holds a word (buffer is empty outside RUN).
    assign m_valid  = (state_q == ST_RUN) && (buf_cnt_q != '0);
    assign m_data   = buf_mem[rd_ptr_q];
    assign xfer_c   = m_valid && m_ready;
    assign word_cnt = word_cnt_q;

    // Number of pops issued whose data has not yet been captured.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < SR_W; i++) begin
            inflight_c = inflight_c + SUM_W'(sr_q[i]);
        end
    end

    // Occupancy the buffer would have if every outstanding read landed now.
    assign occ_c = SUM_W'(buf_cnt_q) + inflight_c - SUM_W'(xfer_c);

    // In-flight marker pipeline; with zero latency the capture is the pop itself.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign sr_q      = '0;
            assign capture_c = pop_c;
        end else begin : g_latn
            always_ff @(posedge clk_d) begin
                if (rst_d) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= SR_W'({sr_q, pop_c});
                end
            end
            assign capture_c = sr_q[SR_W-1];
        end
    endgenerate

    // Captured words land only in RUN; the flush request cycle and CLR empty the buffer.
    assign buf_clr_c = ((state_q == ST_RUN) && flush_req) || (state_q == ST_CLR);
    assign wr_en_c   = capture_c && (state_q == ST_RUN) && !buf_clr_c;

    // Buffer storage.
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            buf_mem[wr_ptr_q] <= fifo_data_d;
        end
    end

    // Buffer pointers and occupancy; simultaneous write and read hold the count.
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            buf_cnt_q <= '0;
        end else if (buf_clr_c) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            buf_cnt_q <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (xfer_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({wr_en_c, xfer_c})
                2'b10:   buf_cnt_q <= buf_cnt_q + BC_W'(1);
                2'b01:   buf_cnt_q <= buf_cnt_q - BC_W'(1);
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    // Delivered-word counter, wraps naturally.
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            word_cnt_q <= '0;
        end else if (xfer_c) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state: flush drains reads, clears for one cycle, then waits for completion.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_c == '0) begin
                    state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_clr_cmplt_d) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM outputs: pop only in RUN with room for every outstanding read, and not while a flush starts.
    always_comb begin
        pop_c      = 1'b0;
        fifo_clr_d = 1'b0;
        flush_busy = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                flush_busy = 1'b0;
                pop_c      = !fifo_empty_d && !flush_req && (occ_c < SUM_W'(DEPTH));
            end
            ST_CLR: begin
                fifo_clr_d = 1'b1;
            end
            default: begin
                pop_c = 1'b0;
            end
        endcase
        fifo_pop_d_n = !pop_c;
    end

endmodule

// File: tb/tb_fifo_2c_pop_reader.sv
// tb_fifo_2c_pop_reader
// Directed bench: three readers (RD_LAT=1, 2 with CNT_W=4, and 0), each fed by
// a simple FIFO model with the matching registered read latency.
module tb_fifo_2c_pop_reader;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] empty;
    logic [2:0] pop_n;
    logic [2:0] clr;
    logic [2:0] cmplt;
    logic [2:0] mv;
    logic [2:0] rdy;
    logic [2:0] flush;
    logic [2:0] busy;
    logic [7:0] fd0, fd1, fd2;
    logic [7:0] md0, md1, md2;
    logic [15:0] wc0;
    logic [3:0]  wc1;
    logic [15:0] wc2;

    // FIFO model state
    logic [7:0] mem [3][256];
    logic [7:0] rp [3] = '{default: 8'd0};
    logic [7:0] wp [3] = '{default: 8'd0};
    logic [7:0] d1 [3] = '{default: 8'd0};
    logic [7:0] d2 [3] = '{default: 8'd0};
    int         clr_cnt [3] = '{default: 0};

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Hand-derived expectations for RD_LAT=2 with m_ready pattern 1,0,0,1
    int t2_pop [14] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    int t2_md  [14] = '{0, 0, 0, 'h21, 'h22, 'h23, 'h23, 'h23, 'h24, 'h25, 'h25, 'h25, 'h26, 0};

    fifo_2c_pop_reader #(.WIDTH(8), .RD_LAT(1), .CNT_W(16)) u0 (
        .clk_d(clk), .rst_d(rst[0]), .fifo_empty_d(empty[0]), .fifo_data_d(fd0),
        .fifo_pop_d_n(pop_n[0]), .fifo_clr_d(clr[0]), .fifo_clr_cmplt_d(cmplt[0]),
        .m_valid(mv[0]), .m_data(md0), .m_ready(rdy[0]), .flush_req(flush[0]),
        .flush_busy(busy[0]), .word_cnt(wc0)
    );

    fifo_2c_pop_reader #(.WIDTH(8), .RD_LAT(2), .CNT_W(4)) u1 (
        .clk_d(clk), .rst_d(rst[1]), .fifo_empty_d(empty[1]), .fifo_data_d(fd1),
        .fifo_pop_d_n(pop_n[1]), .fifo_clr_d(clr[1]), .fifo_clr_cmplt_d(cmplt[1]),
        .m_valid(mv[1]), .m_data(md1), .m_ready(rdy[1]), .flush_req(flush[1]),
        .flush_busy(busy[1]), .word_cnt(wc1)
    );

    fifo_2c_pop_reader #(.WIDTH(8), .RD_LAT(0), .CNT_W(16)) u2 (
        .clk_d(clk), .rst_d(rst[2]), .fifo_empty_d(empty[2]), .fifo_data_d(fd2),
        .fifo_pop_d_n(pop_n[2]), .fifo_clr_d(clr[2]), .fifo_clr_cmplt_d(cmplt[2]),
        .m_valid(mv[2]), .m_data(md2), .m_ready(rdy[2]), .flush_req(flush[2]),
        .flush_busy(busy[2]), .word_cnt(wc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty[0] = (rp[0] == wp[0]);
    assign empty[1] = (rp[1] == wp[1]);
    assign empty[2] = (rp[2] == wp[2]);
    assign fd0 = d1[0];
    assign fd1 = d2[1];
    assign fd2 = mem[2][rp[2]];

    // FIFO model: pop advances the read pointer, data appears after the latency pipe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr[i]) begin
                rp[i] <= wp[i];
                clr_cnt[i] <= clr_cnt[i] + 1;
            end else if (!pop_n[i]) begin
                rp[i] <= rp[i] + 8'd1;
            end
            d1[i] <= (!pop_n[i] && !clr[i]) ? mem[i][rp[i]] : 8'hEE;
            d2[i] <= d1[i];
        end
    end

    task automatic load(input int i, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            mem[i][wp[i] + 8'(k)] = first + 8'(k);
        end
        wp[i] = wp[i] + 8'(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 256; k++) begin
                mem[i][k] = 8'h00;
            end
        end
        rst   = 3'b111;
        rdy   = 3'b000;
        flush = 3'b000;
        cmplt = 3'b000;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pop_n[%0d]", i), pop_n[i], 1'b1);
            chk($sformatf("rst_clr[%0d]", i), clr[i], 1'b0);
            chk($sformatf("rst_valid[%0d]", i), mv[i], 1'b0);
            chk($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
        end
        chk("rst_md0", md0, 8'h00);
        chk("rst_md1", md1, 8'h00);
        chk("rst_wc0", wc0, 16'd0);
        chk("rst_wc1", wc1, 4'd0);
        rst = 3'b000;
        @(negedge clk);

        // RD_LAT=1 streaming, m_ready held high
        load(0, 8'h11, 8);
        rdy[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("t1_pop_n[%0d]", k), pop_n[0], (k < 8) ? 1'b0 : 1'b1);
            chk($sformatf("t1_valid[%0d]", k), mv[0], (k >= 2 && k < 10) ? 1'b1 : 1'b0);
            if (k >= 2 && k < 10) chk($sformatf("t1_data[%0d]", k), md0, 32'(8'h11 + 8'(k - 2)));
            @(negedge clk);
        end
        chk("t1_wc", wc0, 16'd8);

        // RD_LAT=0 streaming: output lags FIFO data by one cycle
        load(2, 8'h40, 10);
        rdy[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("t3_pop_n[%0d]", k), pop_n[2], (k < 10) ? 1'b0 : 1'b1);
            chk($sformatf("t3_valid[%0d]", k), mv[2], (k >= 1 && k < 11) ? 1'b1 : 1'b0);
            if (k >= 1 && k < 11) chk($sformatf("t3_data[%0d]", k), md2, 32'(8'h40 + 8'(k - 1)));
            @(negedge clk);
        end
        chk("t3_wc", wc2, 16'd10);

        // RD_LAT=2 with backpressure pattern 1,0,0,1
        load(1, 8'h21, 6);
        for (int k = 0; k < 14; k++) begin
            rdy[1] = ((k % 4) == 0) || ((k % 4) == 3);
            #1;
            chk($sformatf("t2_pop_n[%0d]", k), pop_n[1], 32'(t2_pop[k]));
            chk($sformatf("t2_valid[%0d]", k), mv[1], (k >= 3 && k < 13) ? 1'b1 : 1'b0);
            if (k >= 3 && k < 13) chk($sformatf("t2_data[%0d]", k), md1, 32'(t2_md[k]));
            @(negedge clk);
        end
        chk("t2_wc", wc1, 4'd6);

        // Flush with two reads in flight and one word buffered, m_ready low
        rdy[1] = 1'b0;
        load(1, 8'h31, 8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush[1] = 1'b1;
        #1;
        chk("fl_j3_valid", mv[1], 1'b1);
        chk("fl_j3_data", md1, 8'h31);
        chk("fl_j3_pop_n", pop_n[1], 1'b1);
        @(negedge clk);
        flush[1] = 1'b0;
        #1;
        chk("fl_j4_valid", mv[1], 1'b0);
        chk("fl_j4_busy", busy[1], 1'b1);
        chk("fl_j4_pop_n", pop_n[1], 1'b1);
        chk("fl_j4_clr", clr[1], 1'b0);
        @(negedge clk);
        chk("fl_j5_clr", clr[1], 1'b0);
        chk("fl_j5_busy", busy[1], 1'b1);
        @(negedge clk);
        chk("fl_j6_clr", clr[1], 1'b1);
        chk("fl_j6_busy", busy[1], 1'b1);
        @(negedge clk);
        chk("fl_j7_clr", clr[1], 1'b0);
        chk("fl_j7_busy", busy[1], 1'b1);
        flush[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        cmplt[1] = 1'b1;
        #1;
        chk("fl_j8_busy", busy[1], 1'b1);
        @(negedge clk);
        cmplt[1] = 1'b0;
        #1;
        chk("fl_j9_busy", busy[1], 1'b0);
        chk("fl_j9_valid", mv[1], 1'b0);
        chk("fl_j9_pop_n", pop_n[1], 1'b1);
        chk("fl_j9_wc", wc1, 4'd6);
        @(negedge clk);
        chk("fl_j10_busy", busy[1], 1'b0);
        chk("fl_clr_pulses", clr_cnt[1], 1);

        // Reset while waiting for clear-complete
        flush[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        @(negedge clk);
        chk("rw_j2_clr", clr[1], 1'b1);
        @(negedge clk);
        chk("rw_j3_busy", busy[1], 1'b1);
        chk("rw_j3_clr", clr[1], 1'b0);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rw_busy", busy[1], 1'b0);
        chk("rw_clr", clr[1], 1'b0);
        chk("rw_valid", mv[1], 1'b0);
        chk("rw_data", md1, 8'h00);
        chk("rw_wc", wc1, 4'd0);
        chk("rw_pop_n", pop_n[1], 1'b1);
        rst[1] = 1'b0;
        @(negedge clk);
        cmplt[1] = 1'b1;
        #1;
        chk("rw_j5_busy", busy[1], 1'b0);
        @(negedge clk);
        cmplt[1] = 1'b0;
        #1;
        chk("rw_j6_busy", busy[1], 1'b0);
        chk("rw_j6_clr", clr[1], 1'b0);
        chk("rw_clr_pulses", clr_cnt[1], 2);

        // word_cnt wrap at CNT_W=4: 17 transfers
        load(1, 8'h60, 17);
        rdy[1] = 1'b1;
        repeat (25) @(negedge clk);
        chk("wrap_wc", wc1, 4'd1);
        chk("wrap_valid", mv[1], 1'b0);
        chk("wrap_busy", busy[1], 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
